icb_ext_sram_slave: RTL and testbench

ICB extended-protocol responder backing a single-port word SRAM. It serves the three-channel (cmd / wr / rsp) transactions issued by the tile loaders (bias, IA, weight) and by the OA writeback path. It is the slave-side endpoint for the bus-fabric and loader testbenches, and the on-chip scratch memory in standalone DSA builds. It accepts one transaction at a time, supports incrementing bursts of `len+1` beats, applies byte-mask writes, and flags out-of-range or misaligned beats with `rsp_err`.

---
 rtl/icb_ext_sram_slave.sv | 171 +++++++++++++++++
 tb/tb_icb_ext_sram_slave.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_ext_sram_slave.sv
// icb_ext_sram_slave
// ICB extended-protocol responder in front of a single-port word SRAM.
// One transaction at a time. Incrementing bursts of len+1 beats. Byte-masked
// writes. Out-of-range and misaligned beats are flagged with rsp_err.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_addr/cmd_read/cmd_len   first-beat byte address, direction, beats-1
//   w_valid/w_ready             write-data beat handshake
//   wdata/wmask                 write data and byte enables
//   rsp_valid/rsp_ready         response beat handshake
//   rsp_rdata/rsp_err           read data (0 on writes and errors), beat error
//   busy                        high whenever a transaction is in progress
module icb_ext_sram_slave #(
    parameter int              AW        = 32,
    parameter int              DW        = 32,
    parameter int              DEPTH     = 1024,
    parameter logic [AW-1:0]   BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [AW-1:0]   cmd_addr,
    input  logic            cmd_read,
    input  logic [2:0]      cmd_len,
    input  logic            w_valid,
    output logic            w_ready,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wmask,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            busy
);

    localparam int            BYTES      = DW / 8;
    localparam int            LG         = $clog2(BYTES);
    localparam int            IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] ALIGN_MASK = AW'(BYTES - 1);
    localparam logic [AW-1:0] DEPTH_W    = AW'(DEPTH);
    localparam logic [AW-1:0] STEP       = AW'(BYTES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_RSP  = 3'd2,
        WR_DATA = 3'd3,
        WR_RSP  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [AW-1:0]   cur_addr;
    logic [2:0]      beats_left;
    logic            err_acc;
    logic            rd_err;
    logic [DW-1:0]   rd_data;
    logic [DW-1:0]   mem [DEPTH];

    logic [AW-1:0]   off;
    logic [AW-1:0]   word_idx;
    logic            beat_err;

    // Beat decode. The subtraction wraps, so addresses below the base land far
    // beyond DEPTH and fall out through the same range compare.
    assign off      = cur_addr - BASE_ADDR;
    assign word_idx = off >> LG;
    assign beat_err = ((cur_addr & ALIGN_MASK) != '0) || (word_idx >= DEPTH_W);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_read ? RD_ADDR : WR_DATA;
            RD_ADDR: state_nxt = RD_RSP;
            RD_RSP:  if (rsp_ready) state_nxt = (beats_left == 3'd0) ? IDLE : RD_ADDR;
            WR_DATA: if (w_valid && (beats_left == 3'd0)) state_nxt = WR_RSP;
            WR_RSP:  if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the state only, so rsp_ready never feeds
    // rsp_valid combinationally and everything falls to reset values with state.
    always_comb begin
        cmd_ready = 1'b0;
        w_ready   = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            RD_RSP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rd_data;
                rsp_err   = rd_err;
            end
            WR_DATA: w_ready = 1'b1;
            WR_RSP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_acc;
            end
            default: ;
        endcase
    end

    // Transaction bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr   <= '0;
            beats_left <= 3'd0;
            err_acc    <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr   <= cmd_addr;
                        beats_left <= cmd_len;
                        err_acc    <= 1'b0;
                    end
                end
                RD_ADDR: rd_err <= beat_err;
                RD_RSP: begin
                    if (rsp_ready) begin
                        cur_addr <= cur_addr + STEP;
                        if (beats_left != 3'd0) beats_left <= beats_left - 3'd1;
                    end
                end
                WR_DATA: begin
                    if (w_valid) begin
                        cur_addr <= cur_addr + STEP;
                        if (beat_err) err_acc <= 1'b1;
                        if (beats_left != 3'd0) beats_left <= beats_left - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // SRAM array and read register; contents survive reset
    always_ff @(posedge clk) begin
        if (state == RD_ADDR) begin
            rd_data <= beat_err ? '0 : mem[word_idx[IW-1:0]];
        end
        if ((state == WR_DATA) && w_valid && !beat_err) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wmask[i]) mem[word_idx[IW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_icb_ext_sram_slave.sv
// Self-checking bench for icb_ext_sram_slave: directed cases from the test
// plan, then randomized transactions, all checked against a transaction-level
// model (word array + expected-response queue + timing rules).
module tb_icb_ext_sram_slave;
    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_read = 1'b0;
    logic [2:0]  cmd_len = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    icb_ext_sram_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_read(cmd_read), .cmd_len(cmd_len),
        .w_valid(w_valid), .w_ready(w_ready), .wdata(wdata), .wmask(wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [31:0] d; logic e; } rsp_t;
    rsp_t        expq[$];
    logic [31:0] mdl[DEPTH];
    logic [31:0] wd[8];
    logic [3:0]  wm[8];
    logic [31:0] cap_d[$];

    function automatic bit addr_err(input logic [31:0] a);
        longint ua, ub;
        ua = {32'h0, a};
        ub = {32'h0, BASE};
        return ((ua % 4) != 0) || (ua < ub) || ((ua - ub) >= DEPTH * 4);
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        longint ua, ub;
        ua = {32'h0, a};
        ub = {32'h0, BASE};
        return int'((ua - ub) / 4);
    endfunction

    task automatic model_read(input logic [31:0] a, input int len);
        rsp_t r;
        for (int b = 0; b <= len; b++) begin
            if (addr_err(a + 32'(4 * b))) begin
                r.d = '0; r.e = 1'b1;
            end else begin
                r.d = mdl[addr_idx(a + 32'(4 * b))]; r.e = 1'b0;
            end
            expq.push_back(r);
        end
    endtask

    // Per-cycle protocol rules plus response scoreboard
    bit          m_act, m_rd, m_wait, prev_stall;
    int          m_wleft, m_rleft;
    longint      m_due;
    logic [31:0] prev_d;
    logic        prev_e;

    always @(negedge clk) begin
        rsp_t r;
        if (!rst_n) begin
            m_act = 0; m_rd = 0; m_wait = 0; m_wleft = 0; m_rleft = 0; prev_stall = 0;
        end else begin
            check("busy", busy, m_act);
            check("cmd_ready", cmd_ready, !m_act);
            check("w_ready", w_ready, m_act && !m_rd && (m_wleft > 0));
            check("rsp_valid", rsp_valid, m_act && m_wait && (cyc >= m_due));
            if (prev_stall) begin
                check("hold_rdata", rsp_rdata, prev_d);
                check("hold_err", rsp_err, prev_e);
            end
            if (cmd_valid && cmd_ready) begin
                m_act = 1; m_rd = cmd_read; m_wait = cmd_read; m_due = cyc + 2;
                m_rleft = cmd_read ? int'(cmd_len) + 1 : 0;
                m_wleft = cmd_read ? 0 : int'(cmd_len) + 1;
            end else if (w_valid && w_ready) begin
                m_wleft--;
                if (m_wleft == 0) begin m_wait = 1; m_due = cyc + 1; end
            end
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    r = expq.pop_front();
                    check("rsp_rdata", rsp_rdata, r.d);
                    check("rsp_err", rsp_err, r.e);
                end
                if (m_rd && m_rleft > 1) begin m_rleft--; m_due = cyc + 2; end
                else begin m_act = 0; m_wait = 0; m_rleft = 0; end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_d = rsp_rdata;
            prev_e = rsp_err;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic [31:0] a, input bit rd, input int len, output longint c);
        bit hs = 0;
        int n = 0;
        c = -1;
        cmd_valid = 1; cmd_addr = a; cmd_read = rd; cmd_len = 3'(len);
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = cmd_ready;
            c = cyc;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 0; cmd_addr = $urandom; cmd_len = 3'($urandom);
        if (!hs) check("cmd_timeout", 0, 1);
    endtask

    task automatic send_writes(input logic [31:0] a, input int len);
        bit   hs;
        int   n;
        bit   acc = 0;
        rsp_t r;
        logic [31:0] ba;
        for (int b = 0; b <= len; b++) begin
            while ($urandom_range(3) == 0) begin
                w_valid = 0; wdata = $urandom;
                @(posedge clk); #1;
            end
            w_valid = 1; wdata = wd[b]; wmask = wm[b];
            hs = 0; n = 0;
            while (!hs && n < 100) begin
                @(negedge clk);
                hs = w_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!hs) check("w_timeout", 0, 1);
            ba = a + 32'(4 * b);
            if (addr_err(ba)) acc = 1;
            else for (int i = 0; i < 4; i++)
                if (wm[b][i]) mdl[addr_idx(ba)][8*i +: 8] = wd[b][8*i +: 8];
        end
        w_valid = 0;
        r.d = '0; r.e = acc;
        expq.push_back(r);
    endtask

    // mode 0: always ready, 1: random, 2: pattern 1,0,0 repeating
    task automatic collect(input int nb, input int mode,
                           output logic [31:0] d, output logic e, output longint c);
        int got = 0;
        int n = 0;
        d = 'x; e = 'x; c = -1;
        cap_d.delete();
        while (got < nb && n < 400) begin
            case (mode)
                0: rsp_ready = 1;
                1: rsp_ready = ($urandom_range(2) != 0);
                default: rsp_ready = ((n % 3) == 0);
            endcase
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                got++; d = rsp_rdata; e = rsp_err; c = cyc;
                cap_d.push_back(rsp_rdata);
            end
            @(posedge clk); #1;
            n++;
        end
        rsp_ready = 0;
        if (got < nb) check("rsp_timeout", got, nb);
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input int mode,
                            output logic [31:0] d, output logic e);
        longint c, c2;
        send_cmd(a, 0, len, c);
        send_writes(a, len);
        collect(1, mode, d, e, c2);
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input int mode,
                           output logic [31:0] d, output logic e, output longint c, output longint c2);
        send_cmd(a, 1, len, c);
        model_read(a, len);
        collect(len + 1, mode, d, e, c2);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        longint      c, c2;
        int          len, sel;
        logic [31:0] a;
        bit          rd;

        // reset values
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_w_ready", w_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // preload every word so the model is fully known
        for (int k = 0; k < DEPTH / 8; k++) begin
            for (int b = 0; b < 8; b++) begin wd[b] = $urandom; wm[b] = 4'hF; end
            do_write(BASE + 32'(32 * k), 7, 1, d, e);
        end

        // write then read
        wd[0] = 32'hDEAD_BEEF; wm[0] = 4'hF;
        do_write(BASE + 32'h10, 0, 0, d, e);
        check("wr_rsp_rdata", d, 0);
        check("wr_rsp_err", e, 0);
        do_read(BASE + 32'h10, 0, 0, d, e, c, c2);
        check("rd_deadbeef", d, 32'hDEAD_BEEF);
        check("rd_deadbeef_err", e, 0);
        check("rd_latency", c2 - c, 2);

        // partial mask
        wd[0] = 32'h1111_2222; wm[0] = 4'h3;
        do_write(BASE + 32'h10, 0, 1, d, e);
        do_read(BASE + 32'h10, 0, 1, d, e, c, c2);
        check("rd_partial", d, 32'hDEAD_2222);

        // burst read with backpressure
        for (int b = 0; b < 4; b++) begin wd[b] = 32'hA0 + 32'(b); wm[b] = 4'hF; end
        do_write(BASE, 3, 0, d, e);
        do_read(BASE, 3, 2, d, e, c, c2);
        check("burst_beats", cap_d.size(), 4);
        for (int b = 0; b < 4; b++)
            if (b < cap_d.size()) check("burst_data", cap_d[b], 32'hA0 + 32'(b));

        // range error
        wd[0] = 32'h55; wd[1] = 32'h66; wm[0] = 4'hF; wm[1] = 4'hF;
        do_write(BASE + 32'((DEPTH - 1) * 4), 1, 0, d, e);
        check("range_wr_err", e, 1);
        do_read(BASE + 32'((DEPTH - 1) * 4), 0, 0, d, e, c, c2);
        check("range_last_word", d, 32'h55);
        do_read(BASE + 32'(DEPTH * 4), 0, 0, d, e, c, c2);
        check("range_rd_err", e, 1);
        check("range_rd_data", d, 0);

        // misalignment
        do_read(BASE + 32'h2, 0, 0, d, e, c, c2);
        check("misal_rd_err", e, 1);
        check("misal_rd_data", d, 0);
        wd[0] = 32'hFFFF_FFFF; wm[0] = 4'hF;
        do_write(BASE + 32'h6, 0, 0, d, e);
        check("misal_wr_err", e, 1);
        do_read(BASE + 32'h4, 0, 0, d, e, c, c2);
        check("misal_mem_kept", d, 32'hA1);

        // reset during the third beat of a len=7 read
        send_cmd(BASE, 1, 7, c);
        model_read(BASE, 7);
        collect(2, 0, d, e, c2);
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
            if (!rsp_valid) check("third_beat_timeout", 0, 1);
        end
        #2 rst_n = 0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_busy", busy, 0);
        expq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        do_read(BASE + 32'h10, 0, 0, d, e, c, c2);
        check("postrst_data", d, 32'hDEAD_2222);
        check("postrst_latency", c2 - c, 2);

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            rd  = 1'($urandom);
            len = $urandom_range(7);
            sel = $urandom_range(9);
            if (sel <= 6)      a = BASE + 32'(4 * $urandom_range(DEPTH - 1));
            else if (sel == 7) a = BASE + 32'(4 * (DEPTH - 1 - $urandom_range(2)));
            else if (sel == 8) a = BASE + 32'(4 * $urandom_range(DEPTH - 1)) + 32'($urandom_range(1, 3));
            else               a = BASE - 32'(4 * $urandom_range(1, 4));
            if (rd) do_read(a, len, 1, d, e, c, c2);
            else begin
                for (int b = 0; b < 8; b++) begin wd[b] = $urandom; wm[b] = 4'($urandom); end
                do_write(a, len, 1, d, e);
            end
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        check("expq_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
